// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor datapath:
// FSM state encoding and a constant-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - borrow_in.
// The borrow leaves toward the next more significant bit.
module full_subtractor (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_borrow,
  output logic o_diff,
  output logic o_borrow
);

  assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
  assign o_borrow = (~i_bit1 & i_bit2)
                  | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// Multi-cycle unsigned subtractor: one CHUNK-bit borrow-ripple
// slice per cycle, result {borrow, A-B} behind valid/ready.
module ripple_borrow_subtractor_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 50,
  parameter int CHUNK = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t          state_q;
  logic [PW-1:0]   a_q;
  logic [PW-1:0]   b_q;
  logic [PW-1:0]   diff_q;
  logic [PW-1:0]   diff_d;
  logic            borrow_q;
  logic [CW-1:0]   cnt_q;

  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_diff;
  logic [CHUNK:0]   bw;
  logic             last;

  assign sl_a  = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign sl_b  = b_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign bw[0] = borrow_q;
  assign last  = (cnt_q == CW'(NCHUNK - 1));

  for (genvar i = 0; i < CHUNK; i++) begin : g_fs
    full_subtractor u_fs (
      .i_bit1   (sl_a[i]),
      .i_bit2   (sl_b[i]),
      .i_borrow (bw[i]),
      .o_diff   (sl_diff[i]),
      .o_borrow (bw[i+1])
    );
  end

  always_comb begin
    diff_d = diff_q;
    diff_d[int'(cnt_q)*CHUNK +: CHUNK] = sl_diff;
  end

  // Padding bits are 0-0, so the last slice borrow is the true borrow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q      <= PW'(i_sub_term1);
            b_q      <= PW'(i_sub_term2);
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            o_ready  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          diff_q   <= diff_d;
          borrow_q <= bw[CHUNK];
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            o_valid  <= 1'b1;
            o_result <= {bw[CHUNK], diff_d[WIDTH-1:0]};
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Scoreboard bench for the multi-cycle borrow-ripple subtractor,
// default CHUNK=10 instance plus a CHUNK=7 instance.
module tb_ripple_borrow_subtractor_seq;

  localparam int W = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         v, rdy_o, vo, rdy_i;
  logic [W-1:0] a, b;
  logic [W:0]   res;

  logic         v7, rdy7_o, vo7, rdy7_i;
  logic [W-1:0] a7, b7;
  logic [W:0]   res7;

  int tests = 0;
  int fails = 0;

  logic [W:0] q[$];
  logic [W:0] q7[$];
  int         acc7[$];

  ripple_borrow_subtractor_seq #(.WIDTH(W), .CHUNK(10)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(v), .o_ready(rdy_o),
    .i_sub_term1(a), .i_sub_term2(b),
    .o_valid(vo), .i_ready(rdy_i),
    .o_result(res)
  );

  ripple_borrow_subtractor_seq #(.WIDTH(W), .CHUNK(7)) dut7 (
    .i_clk(clk), .i_rst(rst),
    .i_valid(v7), .o_ready(rdy7_o),
    .i_sub_term1(a7), .i_sub_term2(b7),
    .o_valid(vo7), .i_ready(rdy7_i),
    .o_result(res7)
  );

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {(x < y), d};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Drive one operand pair on the default DUT; returns at the
  // falling edge just after the accept edge, with operands scrambled.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL send_ready got %b want 1", rdy_o);
    end
    a = x;
    b = y;
    v = 1'b1;
    q.push_back(ref_sub(x, y));
    @(negedge clk);
    v = 1'b0;
    a = rnd();
    b = rnd();
  endtask

  // Wait for a result; lat>0 also checks cycles from accept cycle.
  task automatic recv(input int lat, input string nm);
    int n;
    logic [W:0] e;
    n = 0;
    while (!vo && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (vo !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout got o_valid=%b want 1", nm, vo);
      return;
    end
    e = (q.size() > 0) ? q.pop_front() : 'x;
    if (res !== e) begin
      fails++;
      $display("FAIL %s_result got %h want %h", nm, res, e);
    end
    if (lat > 0) begin
      tests++;
      if (n + 1 != lat) begin
        fails++;
        $display("FAIL %s_latency got %0d want %0d", nm, n + 1, lat);
      end
    end
    rdy_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v = 0; a = '0; b = '0; rdy_i = 1'b1;
    v7 = 0; a7 = '0; b7 = '0; rdy7_i = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({rdy_o, vo, res} !== {1'b1, 1'b0, {(W+1){1'b0}}}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h want 1 0 0",
               rdy_o, vo, res);
    end
    rst = 1'b0;
    send(50'd12345, 50'd45);
    recv(0, "pre_reset");
    send(50'd77, 50'd7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({rdy_o, vo, res} !== {1'b1, 1'b0, {(W+1){1'b0}}}) begin
      fails++;
      $display("FAIL midrun_reset got rdy=%b vld=%b res=%h want 1 0 0",
               rdy_o, vo, res);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (vo !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard got o_valid=%b want 0", vo);
    end
    send(50'd500, 50'd200);
    recv(6, "post_reset");
  endtask

  task automatic test_basic();
    send(50'd1000, 50'd1);
    recv(6, "basic_999");
  endtask

  task automatic test_wrap();
    send(50'd0, 50'd1);
    recv(6, "wrap_0_1");
    send({W{1'b1}}, 50'd0);
    recv(0, "max_minus_0");
  endtask

  task automatic test_stall();
    logic [W:0] held;
    rdy_i = 1'b0;
    send(50'h2_AAAA_AAAA_AAAA, 50'h2_AAAA_AAAA_AAAA);
    while (!vo) @(negedge clk);
    held = res;
    tests++;
    if (held !== {(W+1){1'b0}}) begin
      fails++;
      $display("FAIL equal_zero got %h want 0", held);
    end
    for (int i = 0; i < 10; i++) begin
      v = i[0];
      a = rnd();
      b = rnd();
      @(negedge clk);
      tests++;
      if (vo !== 1'b1 || res !== held || rdy_o !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold got vld=%b rdy=%b res=%h want 1 0 %h",
                 vo, rdy_o, res, held);
      end
    end
    v = 1'b0;
    q.pop_front();
    rdy_i = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    tests++;
    if (vo !== 1'b0 || rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL stall_no_queue got vld=%b rdy=%b want 0 1", vo, rdy_o);
    end
  endtask

  task automatic test_back_to_back();
    int last_acc;
    int naccept;
    int nres;
    logic [W:0] e;
    last_acc = -1;
    naccept = 0;
    nres = 0;
    rdy_i = 1'b1;
    q.delete();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (vo) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        nres++;
        tests++;
        if (res !== e) begin
          fails++;
          $display("FAIL b2b_result got %h want %h", res, e);
        end
      end
      v = 1'b1;
      a = rnd();
      b = rnd();
      if (rdy_o) begin
        if (last_acc >= 0) begin
          tests++;
          if (k - last_acc != 7) begin
            fails++;
            $display("FAIL b2b_spacing got %0d want 7", k - last_acc);
          end
        end
        last_acc = k;
        naccept++;
        q.push_back(ref_sub(a, b));
      end
    end
    @(negedge clk);
    v = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (naccept < 5 || nres < naccept - 1) begin
      fails++;
      $display("FAIL b2b_count got acc=%0d res=%0d want >=5 and res>=acc-1",
               naccept, nres);
    end
  endtask

  task automatic test_chunk7_random();
    int cyc;
    int nres;
    int ai;
    logic [W:0] e;
    cyc = 0;
    nres = 0;
    rdy7_i = 1'b1;
    v7 = 1'b0;
    while (nres < 2000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (vo7) begin
        e = (q7.size() > 0) ? q7.pop_front() : 'x;
        ai = (acc7.size() > 0) ? acc7.pop_front() : -100;
        nres++;
        tests++;
        if (res7 !== e) begin
          fails++;
          $display("FAIL c7_result got %h want %h", res7, e);
        end
        if (nres <= 20) begin
          tests++;
          if (cyc - ai != 9) begin
            fails++;
            $display("FAIL c7_latency got %0d want 9", cyc - ai);
          end
        end
      end
      v7 = 1'b1;
      unique case (cyc % 5)
        0: begin a7 = rnd(); b7 = a7; end
        1: begin a7 = '0; b7 = rnd() | 50'd1; end
        2: begin a7 = {W{1'b1}}; b7 = rnd(); end
        default: begin a7 = rnd(); b7 = rnd(); end
      endcase
      if (rdy7_o) begin
        q7.push_back(ref_sub(a7, b7));
        acc7.push_back(cyc);
      end
    end
    v7 = 1'b0;
    tests++;
    if (nres < 2000) begin
      fails++;
      $display("FAIL c7_timeout got %0d results want 2000", nres);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_chunk7_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
